// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM-to-PCM decimation chain sequencer.
//
// Contents:
//   N_MICS, PCM_W, FRM_W : default channel count, sample width and frame tag width
//   CHAN_W               : channel index width
//   seq_state_t          : stream sequencer state (IDLE, STREAM)
//   pcm_t                : one PCM sample
package pdm_pkg;

    localparam int N_MICS = 96;
    localparam int PCM_W  = 16;
    localparam int FRM_W  = 16;
    localparam int CHAN_W = $clog2(N_MICS);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } seq_state_t;

    typedef logic [PCM_W-1:0] pcm_t;

endpackage : pdm_pkg

// File: rtl/pdm_stage_strobe_gen.sv
// Stage clock-enable generator for the decimation chain.
//
// A free-running divider produces the CIC output-rate strobe. Two toggle bits
// halve that rate twice for the half-band stages. The HB2 strobe is then delayed
// by the FIR latency to mark the cycle when pcm_in holds a fresh output frame.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   run      in   enable; low clears the divider and toggle bits, strobes low
//   cic_en   out  CIC output-rate strobe (one cycle every CIC_DEC cycles)
//   hb1_en   out  HB1 output strobe (every 2nd cic_en)
//   hb2_en   out  HB2 / FIR input strobe (every 2nd hb1_en)
//   pcm_load out  hb2_en delayed by FIR_LAT cycles
module pdm_stage_strobe_gen #(
    parameter int CIC_DEC = 128,
    parameter int FIR_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic cic_en,
    output logic hb1_en,
    output logic hb2_en,
    output logic pcm_load
);

    localparam int DIV_W = (CIC_DEC > 1) ? $clog2(CIC_DEC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CIC_DEC - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               hb1_tgl;
    logic               hb2_tgl;
    logic [FIR_LAT-1:0] load_sr;

    // Strobes are decoded from registered state and gated by run, so dropping
    // run silences them in the same cycle.
    assign cic_en   = run && (div_cnt == DIV_LAST);
    assign hb1_en   = cic_en && hb1_tgl;
    assign hb2_en   = hb1_en && hb2_tgl;
    assign pcm_load = load_sr[FIR_LAT-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            hb1_tgl <= 1'b0;
            hb2_tgl <= 1'b0;
        end else if (!run) begin
            // Clearing everything makes a restart phase-clean.
            div_cnt <= '0;
            hb1_tgl <= 1'b0;
            hb2_tgl <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (cic_en) hb1_tgl <= ~hb1_tgl;
            if (hb1_en) hb2_tgl <= ~hb2_tgl;
        end
    end

    // The delay line only clears on rst: a load already in flight when run
    // drops still reaches the sequencer.
    generate
        if (FIR_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) load_sr <= '0;
                else     load_sr <= hb2_en;
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (rst) load_sr <= '0;
                else     load_sr <= {load_sr[FIR_LAT-2:0], hb2_en};
            end
        end
    endgenerate

endmodule : pdm_stage_strobe_gen

// File: rtl/pdm_chain_sequencer.sv
// Single-clock sequencer for the multichannel PDM decimation chain.
//
// Produces the per-stage clock enables, snapshots the parallel PCM bus once per
// output sample period and streams it one channel per beat over valid/ready.
// Frames that arrive while the previous frame is still streaming are dropped
// and counted.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   run      in   strobe generator enable
//   pcm_in   in   flattened FIR outputs, channel k at [k*PCM_W +: PCM_W]
//   cic_en   out  CIC output-rate strobe
//   hb1_en   out  HB1 output strobe
//   hb2_en   out  HB2 / FIR input strobe
//   m_valid  out  stream beat valid
//   m_ready  in   downstream accept
//   m_data   out  sample of the current channel
//   m_chan   out  channel index 0..N-1
//   m_first  out  beat is channel 0
//   m_last   out  beat is channel N-1
//   m_frame  out  frame tag of the current beat
//   ovf      out  sticky overflow flag
//   ovf_clr  in   clears ovf and drop_cnt (a coincident drop wins)
//   drop_cnt out  dropped frames, saturating at 255
module pdm_chain_sequencer #(
    parameter int N       = pdm_pkg::N_MICS,
    parameter int PCM_W   = pdm_pkg::PCM_W,
    parameter int CIC_DEC = 128,
    parameter int FIR_LAT = 3,
    parameter int FRM_W   = pdm_pkg::FRM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [N*PCM_W-1:0] pcm_in,
    output logic               cic_en,
    output logic               hb1_en,
    output logic               hb2_en,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PCM_W-1:0]   m_data,
    output logic [6:0]         m_chan,
    output logic               m_first,
    output logic               m_last,
    output logic [FRM_W-1:0]   m_frame,
    output logic               ovf,
    input  logic               ovf_clr,
    output logic [7:0]         drop_cnt
);

    import pdm_pkg::*;

    localparam logic [6:0] CHAN_LAST = 7'(N - 1);

    logic pcm_load;

    seq_state_t       state, state_n;
    logic [6:0]       chan, chan_n;
    logic [FRM_W-1:0] frame_cnt, frame_cnt_n;
    logic [FRM_W-1:0] frame_tag, frame_tag_n;
    logic             ovf_q, ovf_n;
    logic [7:0]       drop_q, drop_n;
    logic             capture;
    logic             last_acc;
    logic [7:0]       drop_base;

    logic [PCM_W-1:0] cap_buf [N];

    pdm_stage_strobe_gen #(
        .CIC_DEC (CIC_DEC),
        .FIR_LAT (FIR_LAT)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .cic_en   (cic_en),
        .hb1_en   (hb1_en),
        .hb2_en   (hb2_en),
        .pcm_load (pcm_load)
    );

    // Last beat accepted this cycle; a load here is a back-to-back frame, not a drop.
    assign last_acc = (state == STREAM) && m_ready && (chan == CHAN_LAST);

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        state_n     = state;
        chan_n      = chan;
        frame_cnt_n = frame_cnt;
        frame_tag_n = frame_tag;
        ovf_n       = ovf_q;
        drop_n      = drop_q;
        capture     = 1'b0;

        unique case (state)
            IDLE: begin
                if (pcm_load) begin
                    capture = 1'b1;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (chan == CHAN_LAST) begin
                        chan_n  = '0;
                        capture = pcm_load;
                        state_n = pcm_load ? STREAM : IDLE;
                    end else begin
                        chan_n = chan + 7'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (capture) begin
            chan_n      = '0;
            frame_tag_n = frame_cnt;
            frame_cnt_n = frame_cnt + 1'b1;
        end

        // Clear first, then let a coincident drop count on top of the cleared value.
        drop_base = ovf_clr ? 8'd0 : drop_q;
        if (ovf_clr) begin
            ovf_n  = 1'b0;
            drop_n = 8'd0;
        end
        if (pcm_load && (state == STREAM) && !last_acc) begin
            ovf_n  = 1'b1;
            drop_n = (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            chan      <= '0;
            frame_cnt <= '0;
            frame_tag <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state     <= state_n;
            chan      <= chan_n;
            frame_cnt <= frame_cnt_n;
            frame_tag <= frame_tag_n;
            ovf_q     <= ovf_n;
            drop_q    <= drop_n;
        end
    end

    // NOTE: the capture buffer has no reset; its contents are only ever read
    // in STREAM, after a capture has written all of them.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N; k++) begin
                cap_buf[k] <= pcm_in[k*PCM_W +: PCM_W];
            end
        end
    end

    // Outputs are pure functions of registered state, so they stay stable
    // while a beat is stalled.
    assign m_valid  = (state == STREAM);
    assign m_data   = (state == STREAM) ? cap_buf[chan] : '0;
    assign m_chan   = chan;
    assign m_first  = (state == STREAM) && (chan == 7'd0);
    assign m_last   = (state == STREAM) && (chan == CHAN_LAST);
    assign m_frame  = frame_tag;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;

endmodule : pdm_chain_sequencer

// File: doc/pdm_chain_sequencer.md
Name: pdm_chain_sequencer

Overview:
- Single-clock sequencer for the 96-channel PDM-to-PCM decimation chain (CIC, HB1, HB2, FIR).
- Generates the per-stage clock-enable strobes, so the chain runs on one clock instead of divided clocks.
- Snapshots the parallel PCM bus each output sample period and streams it one channel per beat over a valid/ready interface toward the beamformer/host FIFO.
- Detects and counts frames dropped by downstream backpressure.

Parameters:
- N, 96, number of microphone channels.
- PCM_W, 16, PCM sample width.
- CIC_DEC, 128, clk cycles per CIC output strobe; must be >= 2.
- FIR_LAT, 3, clk cycles from hb2_en to valid FIR output on pcm_in.
- FRM_W, 16, frame counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  strobe generator enable.
- pcm_in  in  N*PCM_W  flattened FIR outputs; channel k is bits [k*PCM_W +: PCM_W].
- cic_en  out  1  CIC output-rate strobe.
- hb1_en  out  1  HB1 output strobe.
- hb2_en  out  1  HB2 / FIR input strobe.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  PCM_W  sample.
- m_chan  out  7  channel index, 0..N-1.
- m_first  out  1  beat is channel 0.
- m_last  out  1  beat is channel N-1.
- m_frame  out  FRM_W  frame tag of the current beat.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf and drop_cnt.
- drop_cnt  out  8  dropped frames, saturating at 255.

Behaviour:
- Reset: every output is 0, counters are 0, FSM is IDLE, capture buffer contents are don't-care.
- Strobe generation:
  - div_cnt counts 0..CIC_DEC-1 while run=1 and wraps. cic_en=1 for one cycle when div_cnt==CIC_DEC-1.
  - hb1_en pulses on every 2nd cic_en; hb2_en pulses on every 2nd hb1_en. Coincident pulses are all in the same cycle.
  - First hb2_en after reset falls at cycle 4*CIC_DEC-1 of run=1.
  - run=0 clears div_cnt and both toggle bits the next cycle and holds all strobes low. Restart is phase-clean.
- Load pulse: pcm_load = hb2_en delayed FIR_LAT cycles through a shift register. The register is cleared by rst only, not by run=0.
- FSM states: IDLE, STREAM.
  - IDLE + pcm_load: capture pcm_in into the buffer, m_frame <= frame_cnt, frame_cnt++ (wraps), set chan=0, go to STREAM. m_valid rises the next cycle, i.e. latency of 1 clk.
  - STREAM: m_valid=1. m_data=buf[chan], m_first=(chan==0), m_last=(chan==N-1).
  - On m_valid & m_ready: chan++. If this was the last beat, go to IDLE and drop m_valid.
  - While m_valid & !m_ready, all m_* outputs are held stable.
- Boundary conditions:
  - pcm_load in STREAM, not on the accepted last beat: frame is dropped. Buffer, frame_cnt and stream are untouched. ovf <= 1, drop_cnt++ (saturating).
  - pcm_load on the same cycle as the last-beat accept: no overflow. New frame is captured and the FSM stays in STREAM with chan=0. m_valid stays high and the next beat is the new frame's channel 0.
  - ovf_clr coincident with a drop: the drop wins, so ovf=1 and drop_cnt=1.
  - rst mid-stream: aborts immediately, m_valid=0 next cycle, no partial-frame completion.
  - run=0 mid-stream: the current frame finishes; no new loads arrive once the delay line drains.
- Throughput: N beats per 4*CIC_DEC cycles, which is 96 per 512 at the defaults. Sustained m_ready=1 never overflows.

Decomposition:
- Shared package pdm_pkg:
  - N_MICS=96, PCM_W=16, FRM_W=16, CHAN_W=$clog2(N_MICS).
  - Sequencer state typedef (IDLE, STREAM).
  - pcm_t sample typedef.
- One sub-module, pdm_stage_strobe_gen: div_cnt, toggle bits, cic_en/hb1_en/hb2_en, and the FIR_LAT delay producing pcm_load.
- Top level holds the capture buffer, FSM, frame/drop counters and stream outputs.

Test Plan:
- Strobe timing: rst, run=1, CIC_DEC=128.
  - cic_en at cycles 127, 255, 383, 511.
  - hb1_en at 255, 511.
  - hb2_en at 511.
  - m_valid rises at cycle 511+FIR_LAT+1.
- Stream with m_ready=1: pcm_in channel k = 16'h1000+k.
  - 96 consecutive beats with m_data=1000..105F and m_chan 0..95.
  - m_first only on beat 0, m_last only on beat 95, m_frame=0.
  - Second frame has m_frame=1.
- Backpressure: m_ready toggling 1/0 each cycle.
  - Data and channel are held stable across stall cycles.
  - All 96 beats are in order, ovf stays 0.
- Overflow: m_ready=0 for 1200 cycles.
  - Frame 0 is held at channel 0.
  - Subsequent loads are dropped: ovf=1, drop_cnt=2.
  - ovf_clr then clears both flags to 0.
- Back-to-back boundary: force pcm_load coincident with the channel-95 accept.
  - No ovf.
  - Next beat is the new frame's channel 0 with m_frame incremented.
- Reset and run gating:
  - rst asserted at beat 40 gives m_valid=0 next cycle, all outputs 0, frame tag 0 afterwards.
  - run=0 mid-stream lets the frame complete, after which no strobes occur.
